// File: rtl/arm_ctrl_decode_pipe.sv
// ARM control decoder with condition gating, followed by a DEPTH-stage control
// pipeline with per-stage valid, stall (hold), flush (bubble) and illegal flag.
module arm_ctrl_decode_pipe #(
    parameter int CMD_W   = 4,
    parameter int DEPTH   = 1,
    parameter int COND_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       cond,
    input  logic [1:0]       mode,
    input  logic [3:0]       opcode,
    input  logic             s_in,
    input  logic [3:0]       status,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             wb_en,
    output logic             b,
    output logic             s_out,
    output logic             illegal
);

    typedef struct packed {
        logic             valid;
        logic             ill;
        logic [CMD_W-1:0] cmd;
        logic             mr;
        logic             mw;
        logic             wb;
        logic             br;
        logic             s;
    } entry_t;

    entry_t dec_next;
    entry_t stage_reg [DEPTH];
    entry_t stage_in  [DEPTH];
    entry_t last;
    logic   legal;
    logic   cond_pass;
    logic   flag_n, flag_z, flag_c, flag_v;
    logic   live;

    assign {flag_n, flag_z, flag_c, flag_v} = status;

    always_comb begin
        cond_pass = 1'b1;
        if (COND_EN != 0) begin
            case (cond)
                4'b0000: cond_pass = flag_z;
                4'b0001: cond_pass = !flag_z;
                4'b0010: cond_pass = flag_c;
                4'b0011: cond_pass = !flag_c;
                4'b0100: cond_pass = flag_n;
                4'b0101: cond_pass = !flag_n;
                4'b0110: cond_pass = flag_v;
                4'b0111: cond_pass = !flag_v;
                4'b1000: cond_pass = flag_c && !flag_z;
                4'b1001: cond_pass = !flag_c || flag_z;
                4'b1010: cond_pass = (flag_n == flag_v);
                4'b1011: cond_pass = (flag_n != flag_v);
                4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
                4'b1101: cond_pass = flag_z || (flag_n != flag_v);
                4'b1110: cond_pass = 1'b1;
                default: cond_pass = 1'b0;
            endcase
        end
    end

    always_comb begin
        dec_next = '0;
        legal    = 1'b1;
        case (mode)
            2'b00: begin
                dec_next.s  = s_in;
                dec_next.wb = 1'b1;
                case (opcode)
                    4'b1101: dec_next.cmd = CMD_W'(4'b0001);
                    4'b1111: dec_next.cmd = CMD_W'(4'b1001);
                    4'b0100: dec_next.cmd = CMD_W'(4'b0010);
                    4'b0101: dec_next.cmd = CMD_W'(4'b0011);
                    4'b0010: dec_next.cmd = CMD_W'(4'b0100);
                    4'b0110: dec_next.cmd = CMD_W'(4'b0101);
                    4'b0000: dec_next.cmd = CMD_W'(4'b0110);
                    4'b1100: dec_next.cmd = CMD_W'(4'b0111);
                    4'b0001: dec_next.cmd = CMD_W'(4'b1000);
                    4'b1010: begin
                        dec_next.cmd = CMD_W'(4'b0100);
                        dec_next.wb  = 1'b0;
                        dec_next.s   = 1'b1;
                    end
                    4'b1000: begin
                        dec_next.cmd = CMD_W'(4'b0110);
                        dec_next.wb  = 1'b0;
                        dec_next.s   = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            2'b01: begin
                if (opcode == 4'b0100) begin
                    dec_next.cmd = CMD_W'(4'b0010);
                    dec_next.mr  = s_in;
                    dec_next.mw  = !s_in;
                    dec_next.wb  = s_in;
                end else begin
                    legal = 1'b0;
                end
            end
            2'b10:   dec_next.br = 1'b1;
            default: legal = 1'b0;
        endcase

        // A failed condition outranks an illegal encoding: it never raises illegal.
        if (!in_valid || !cond_pass) begin
            dec_next = '0;
        end else if (!legal) begin
            dec_next       = '0;
            dec_next.valid = 1'b1;
            dec_next.ill   = 1'b1;
        end else begin
            dec_next.valid = 1'b1;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_in[gi] = dec_next;
        end else begin : g_tail
            assign stage_in[gi] = stage_reg[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_reg[gi] <= '0;
            end else if (flush) begin
                stage_reg[gi] <= '0;
            end else if (!stall) begin
                stage_reg[gi] <= stage_in[gi];
            end
        end
    end

    assign last      = stage_reg[DEPTH-1];
    assign live      = last.valid && !last.ill;
    assign out_valid = live;
    assign exe_cmd   = live ? last.cmd : '0;
    assign mem_r_en  = live && last.mr;
    assign mem_w_en  = live && last.mw;
    assign wb_en     = live && last.wb;
    assign b         = live && last.br;
    assign s_out     = live && last.s;
    assign illegal   = last.valid && last.ill;

endmodule

// File: tb/tb_arm_ctrl_decode_pipe.sv
// Scoreboard bench for arm_ctrl_decode_pipe at DEPTH=3: stimulus pushes expected
// output words, a negedge monitor pops them whenever a new entry is presented.
module tb_arm_ctrl_decode_pipe;
    localparam int DEPTH = 3;

    // Packed compare word: {out_valid, exe_cmd[3:0], mem_r_en, mem_w_en, wb_en, b, s_out, illegal}
    localparam logic [10:0] E_ADD  = {1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] E_LDR  = {1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] E_STR  = {1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] E_CMP  = {1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [10:0] E_TST  = {1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [10:0] E_MVN  = {1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [10:0] E_BR   = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] E_ILL  = {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [10:0] E_ORR  = {1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] E_EOR  = {1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] E_MOV  = {1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] E_ZERO = 11'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] cond;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s_in;
    logic [3:0] status;
    logic       stall;
    logic       flush;
    logic       out_valid;
    logic [3:0] exe_cmd;
    logic       mem_r_en, mem_w_en, wb_en, b, s_out, illegal;

    int checks = 0;
    int errors = 0;
    logic [10:0] sb_q[$];
    logic        shifted = 1'b0;
    logic [10:0] obs;

    assign obs = {out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s_out, illegal};

    arm_ctrl_decode_pipe #(.CMD_W(4), .DEPTH(DEPTH), .COND_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cond(cond), .mode(mode),
        .opcode(opcode), .s_in(s_in), .status(status), .stall(stall), .flush(flush),
        .out_valid(out_valid), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .b(b), .s_out(s_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Output registers only advance on an edge without stall/flush while out of reset.
    always @(posedge clk) shifted = rst_n && !stall && !flush;

    always @(negedge clk) begin
        if (rst_n && shifted && (out_valid || illegal)) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_output got=%b expected=none", obs);
            end else begin
                logic [10:0] exp_w;
                exp_w = sb_q.pop_front();
                if (obs !== exp_w) begin
                    errors++;
                    $display("FAIL sb_entry got=%b expected=%b", obs, exp_w);
                end else begin
                    $display("t=%0t sb_entry ok %b", $time, obs);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] m, input logic [3:0] o,
                         input logic s, input logic [3:0] st);
        in_valid = 1'b1; cond = c; mode = m; opcode = o; s_in = s; status = st;
    endtask

    task automatic idle();
        in_valid = 1'b0; cond = 4'b1110; mode = 2'b00; opcode = 4'b0000; s_in = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [10:0] exp_w);
        checks++;
        if (obs !== exp_w) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, obs, exp_w);
        end else begin
            $display("t=%0t %s ok %b", $time, name, obs);
        end
    endtask

    // Issue one instruction for a single cycle; push its expected word if it will emerge.
    task automatic issue(input logic [3:0] c, input logic [1:0] m, input logic [3:0] o,
                         input logic s, input logic [3:0] st, input logic present,
                         input logic [10:0] exp_w);
        drive(c, m, o, s, st);
        if (present) sb_q.push_back(exp_w);
        step();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; status = 4'b0000;
        idle();
        #12;
        check_out("reset_state", E_ZERO);
        step();
        rst_n = 1'b1;
        step();

        // Latency: ADD visible exactly DEPTH edges after issue, not before.
        issue(4'b1110, 2'b00, 4'b0100, 1'b0, 4'b0000, 1'b1, E_ADD);
        idle();
        step();
        check_out("add_latency_early", E_ZERO);
        step();
        check_out("add_latency", E_ADD);

        // Back-to-back load/store, then condition gating and the other decodes.
        issue(4'b1110, 2'b01, 4'b0100, 1'b1, 4'b0000, 1'b1, E_LDR);
        issue(4'b1110, 2'b01, 4'b0100, 1'b0, 4'b0000, 1'b1, E_STR);
        idle();
        step();
        check_out("ldr_out", E_LDR);
        step();
        check_out("str_out", E_STR);

        issue(4'b0000, 2'b00, 4'b1010, 1'b0, 4'b0000, 1'b0, E_ZERO); // EQ fails, Z=0
        issue(4'b0000, 2'b00, 4'b1010, 1'b0, 4'b0100, 1'b1, E_CMP);  // EQ passes
        issue(4'b1110, 2'b00, 4'b1000, 1'b0, 4'b0000, 1'b1, E_TST);
        issue(4'b1110, 2'b00, 4'b1111, 1'b1, 4'b0000, 1'b1, E_MVN);
        issue(4'b1110, 2'b10, 4'b1111, 1'b1, 4'b0000, 1'b1, E_BR);
        issue(4'b1110, 2'b11, 4'b0100, 1'b0, 4'b0000, 1'b1, E_ILL);  // mode 11
        issue(4'b1110, 2'b00, 4'b0011, 1'b0, 4'b0000, 1'b1, E_ILL);  // bad opcode
        issue(4'b1110, 2'b01, 4'b0000, 1'b1, 4'b0000, 1'b1, E_ILL);  // bad mem opcode
        issue(4'b1111, 2'b11, 4'b0000, 1'b0, 4'b0000, 1'b0, E_ZERO); // cond never: no illegal
        issue(4'b1100, 2'b00, 4'b1100, 1'b0, 4'b1001, 1'b1, E_ORR);  // GT pass
        issue(4'b1011, 2'b00, 4'b1100, 1'b0, 4'b1001, 1'b0, E_ZERO); // LT fail
        issue(4'b1000, 2'b00, 4'b0001, 1'b0, 4'b0010, 1'b1, E_EOR);  // HI pass
        issue(4'b1001, 2'b00, 4'b0001, 1'b0, 4'b0010, 1'b0, E_ZERO); // LS fail
        issue(4'b0001, 2'b00, 4'b0001, 1'b0, 4'b0100, 1'b0, E_ZERO); // NE fail
        idle();
        for (int i = 0; i < DEPTH + 1; i++) step();

        // Stall: EOR reaches the output, then everything holds for 3 cycles.
        issue(4'b1110, 2'b00, 4'b0001, 1'b0, 4'b0000, 1'b1, E_EOR);
        issue(4'b1110, 2'b00, 4'b1101, 1'b0, 4'b0000, 1'b1, E_MOV);
        idle();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b1110, 2'b00, 4'b0100, 1'b0, 4'b0000); // must not be captured
            step();
            check_out("stall_hold", E_EOR);
        end
        stall = 1'b0;
        idle();
        step();
        check_out("mov_after_stall", E_MOV);
        step();
        check_out("drain_after_stall", E_ZERO);

        // Stall and flush together kill in-flight entries.
        issue(4'b1110, 2'b00, 4'b0100, 1'b0, 4'b0000, 1'b1, E_ADD);
        stall = 1'b1; flush = 1'b1;
        drive(4'b1110, 2'b00, 4'b1101, 1'b0, 4'b0000);
        step();
        sb_q.delete();
        check_out("flush_clear", E_ZERO);
        stall = 1'b0; flush = 1'b0;
        idle();
        for (int i = 0; i < DEPTH + 1; i++) step();

        // Asynchronous reset with entries in flight.
        issue(4'b1110, 2'b00, 4'b0100, 1'b0, 4'b0000, 1'b1, E_ADD);
        issue(4'b1110, 2'b10, 4'b0000, 1'b0, 4'b0000, 1'b1, E_BR);
        idle();
        step();
        check_out("pre_reset_live", E_ADD);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check_out("async_reset", E_ZERO);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        check_out("post_reset_quiet", E_ZERO);
        issue(4'b1110, 2'b00, 4'b1101, 1'b0, 4'b0000, 1'b1, E_MOV);
        idle();
        for (int i = 0; i < DEPTH + 1; i++) step();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d pending expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
